nexthop_register_bank: RTL and testbench
========================================

// Module: nexthop_register_bank
// PURPOSE
//  Per-input-channel next-hop register bank for the NoC arbiter. Binds each input channel to an output port when a head flit is routed.
//  Holds that binding for the whole wormhole packet and releases it on the tail flit.
//  Outputs the bound port per channel (NULL_HOP when unbound) plus a per-output busy vector that the arbiter uses to mask requests.
// PARAMETERS
//  NUM_IN    5      number of input channels
//  NUM_OUT   4      number of legal output ports; addresses 0..NUM_OUT-1
//  ADDR_W    3      next-hop address width; must satisfy 2**ADDR_W > NUM_OUT
//  NULL_HOP  3'b100 "no route" code driven by unbound channels; must be >= NUM_OUT
//  TO_CYC    16     timeout threshold in cycles (only used with NHR_TIMEOUT_EN)
// PORTS
//  clk            in   1               clock, rising edge
//  reset          in   1               synchronous, active-high
//  ib_empty_i     in   NUM_IN          input buffer empty, per channel
//  nhr_write_i    in   NUM_IN          head-flit route-valid strobe, per channel
//  nhr_address_i  in   NUM_IN*ADDR_W   requested next hop; channel c is in slice [c*ADDR_W +: ADDR_W]
//  nhr_tail_i     in   NUM_IN          tail flit dequeued this cycle, per channel
//  nhr_address_o  out  NUM_IN*ADDR_W   bound next hop, registered; same slicing as nhr_address_i
//  nhr_valid_o    out  NUM_IN          channel is bound (state BOUND)
//  nhr_err_o      out  NUM_IN          1-cycle pulse: a write was rejected
//  out_busy_o     out  NUM_OUT         bit k = OR over channels bound to port k (combinational decode of registered state)
//  nhr_timeout_o  out  NUM_IN          1-cycle timeout-release pulse (port exists only with NHR_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: all channels go to IDLE; nhr_address_o = NULL_HOP; valid, err, busy and timeout all 0. A reset mid-packet drops the binding in the same edge.
//  Per-channel FSM, IDLE/BOUND; all updates occur on the clk edge; one cycle of latency from input to output.
//  IDLE -> BOUND: on nhr_write_i=1, ib_empty_i=0 and address < NUM_OUT; latch the address.
//  Write rejected (state unchanged, err pulse next cycle) when any of:
//   - the address is >= NUM_OUT;
//   - ib_empty_i=1 with write=1 in IDLE;
//   - write=1 in BOUND without tail=1.
//  BOUND -> IDLE: on nhr_tail_i=1; the output returns to NULL_HOP next cycle.
//  BOUND + tail=1 + write=1 with a legal address and ib_empty_i=0: rebind to the new address (stays BOUND); supports back-to-back packets.
//  tail=1 in IDLE: ignored, no error.
//  ib_empty_i=1 while BOUND: the binding is held, since wormhole bubbles are legal; it does not clear the output.
//  Two channels may bind the same output port; arbitration resolves the contention elsewhere, and out_busy_o simply ORs them.
//  nhr_address_o holds the latched value unchanged for the entire BOUND period.
// CONFIGURATION
//  NHR_TIMEOUT_EN defined:
//   - each channel has a $clog2(TO_CYC+1)-bit stall counter, counting cycles with BOUND and ib_empty_i=1;
//   - the counter clears when ib_empty_i=0, on release, and on reset;
//   - when the count reaches TO_CYC, the channel is forced to IDLE and nhr_timeout_o pulses for 1 cycle;
//   - a tail in the same cycle takes priority (normal release, no timeout pulse).
//  NHR_TIMEOUT_EN undefined: no counter and no nhr_timeout_o port; BOUND is left only via tail or reset.
// STRUCTURE
//  Package nhr_pkg: nhr_state_e {NHR_IDLE, NHR_BOUND}; default NULL_HOP constant; helper function legal_hop(addr, num_out).
//  Sub-module nhr_channel: one FSM, address register, error flop and optional stall counter; instantiated NUM_IN times via generate.
//  Top level: port slicing plus the out_busy_o decode only.
// TESTING
//  1 Reset, then idle -> all 5 channels output 3'b100 (x5), valid=0, busy=4'b0000.
//  2 ch0 write addr=2 with ib_empty=0 -> next cycle ch0 out=2, valid=1, busy=4'b0100; 3 cycles later tail -> out=3'b100, busy=0.
//  3 ch1 write addr=5, and ch2 write addr=1 with ib_empty=1 -> both err pulse 1 cycle, both stay at 3'b100.
//  4 ch3 BOUND to 1; write addr=3 with no tail -> err, stays 1; tail+write addr=3 same cycle -> out=3, valid stays 1.
//  5 ch0 and ch4 both bound to 0 -> busy[0]=1; release ch0 -> busy[0] stays 1 until ch4 tail.
//  6 NHR_TIMEOUT_EN, TO_CYC=16: ch2 bound, ib_empty=1 held -> timeout pulse after 16 empty cycles, out=3'b100; repeat with a bubble at cycle 10 -> no timeout.

Source files
------------

// File: rtl/nhr_pkg.sv
// Shared types and helpers for the next-hop register bank: channel FSM states,
// the default "no route" code and the legal-port check.
package nhr_pkg;

   typedef enum logic {
      NHR_IDLE  = 1'b0,
      NHR_BOUND = 1'b1
   } nhr_state_e;

   localparam logic [2:0] NULL_HOP_DEFAULT = 3'b100;

   // Port addresses are dense from zero, so legality is a simple bound check.
   function automatic logic legal_hop(input logic [31:0] addr, input int unsigned num_out);
      return addr < num_out;
   endfunction

endpackage

// File: rtl/nhr_channel.sv
// One input channel's binding: IDLE/BOUND FSM, latched next hop and reject pulse.
// With NHR_TIMEOUT_EN defined, a stall counter force-releases a binding starved for TO_CYC cycles.
module nhr_channel
   import nhr_pkg::*;
#(
   parameter int                NUM_OUT  = 4,
   parameter int                ADDR_W   = 3,
   parameter logic [ADDR_W-1:0] NULL_HOP = ADDR_W'(NULL_HOP_DEFAULT)
`ifdef NHR_TIMEOUT_EN
   ,parameter int               TO_CYC   = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ib_empty,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              tail,
   output logic [ADDR_W-1:0] addr,
   output logic              valid,
   output logic              err
`ifdef NHR_TIMEOUT_EN
   ,output logic             timeout
`endif
);

   nhr_state_e state;
   logic       accept;
   logic       stall_expired;

   assign accept = legal_hop(32'(addr_in), NUM_OUT) && !ib_empty;
   assign valid  = (state == NHR_BOUND);

`ifdef NHR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TO_CYC + 1);

   logic [CNT_W-1:0] stall_cnt;

   // A tail in the same cycle wins, so only tail-less stalled cycles can expire.
   assign stall_expired = (state == NHR_BOUND) && !tail && ib_empty &&
                          (stall_cnt == CNT_W'(TO_CYC - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         if ((state == NHR_BOUND) && !tail && ib_empty) begin
            if (stall_expired) begin
               stall_cnt <= '0;
               timeout   <= 1'b1;
            end else begin
               stall_cnt <= stall_cnt + 1'b1;
            end
         end else begin
            stall_cnt <= '0;
         end
      end
   end
`else
   assign stall_expired = 1'b0;
`endif

   // NOTE: all state here uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= NHR_IDLE;
         addr  <= NULL_HOP;
         err   <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            NHR_IDLE: begin
               if (write) begin
                  if (accept) begin
                     state <= NHR_BOUND;
                     addr  <= addr_in;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            NHR_BOUND: begin
               if (tail) begin
                  // Back-to-back packets: a good head on the tail cycle rebinds.
                  if (write && accept) begin
                     addr <= addr_in;
                  end else begin
                     err   <= write;
                     state <= NHR_IDLE;
                     addr  <= NULL_HOP;
                  end
               end else begin
                  err <= write;
                  if (stall_expired) begin
                     state <= NHR_IDLE;
                     addr  <= NULL_HOP;
                  end
               end
            end
            default: begin
               state <= NHR_IDLE;
               addr  <= NULL_HOP;
            end
         endcase
      end
   end

endmodule

// File: rtl/nexthop_register_bank.sv
// Per-input-channel next-hop bindings for the NoC arbiter plus the per-output busy mask.
// Optional feature macro: NHR_TIMEOUT_EN (stall timeout release and nhr_timeout_o port).
module nexthop_register_bank
   import nhr_pkg::*;
#(
   parameter int                NUM_IN   = 5,
   parameter int                NUM_OUT  = 4,
   parameter int                ADDR_W   = 3,
   parameter logic [ADDR_W-1:0] NULL_HOP = ADDR_W'(NULL_HOP_DEFAULT)
`ifdef NHR_TIMEOUT_EN
   ,parameter int               TO_CYC   = 16
`endif
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_IN-1:0]        ib_empty_i,
   input  logic [NUM_IN-1:0]        nhr_write_i,
   input  logic [NUM_IN*ADDR_W-1:0] nhr_address_i,
   input  logic [NUM_IN-1:0]        nhr_tail_i,
   output logic [NUM_IN*ADDR_W-1:0] nhr_address_o,
   output logic [NUM_IN-1:0]        nhr_valid_o,
   output logic [NUM_IN-1:0]        nhr_err_o,
   output logic [NUM_OUT-1:0]       out_busy_o
`ifdef NHR_TIMEOUT_EN
   ,output logic [NUM_IN-1:0]       nhr_timeout_o
`endif
);

   for (genvar c = 0; c < NUM_IN; c++) begin : g_ch
      nhr_channel #(
         .NUM_OUT  (NUM_OUT),
         .ADDR_W   (ADDR_W),
         .NULL_HOP (NULL_HOP)
`ifdef NHR_TIMEOUT_EN
         ,.TO_CYC  (TO_CYC)
`endif
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .ib_empty (ib_empty_i[c]),
         .write    (nhr_write_i[c]),
         .addr_in  (nhr_address_i[c*ADDR_W +: ADDR_W]),
         .tail     (nhr_tail_i[c]),
         .addr     (nhr_address_o[c*ADDR_W +: ADDR_W]),
         .valid    (nhr_valid_o[c]),
         .err      (nhr_err_o[c])
`ifdef NHR_TIMEOUT_EN
         ,.timeout (nhr_timeout_o[c])
`endif
      );
   end

   // NOTE: busy gets a full default before the loops so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      out_busy_o = '0;
      for (int c = 0; c < NUM_IN; c++) begin
         for (int k = 0; k < NUM_OUT; k++) begin
            if (nhr_valid_o[c] && (nhr_address_o[c*ADDR_W +: ADDR_W] == ADDR_W'(k)))
               out_busy_o[k] = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nexthop_register_bank.sv
// Self-checking bench for nexthop_register_bank: directed scenarios then random traffic,
// compared against a channel-binding model. Covers timeout behaviour when NHR_TIMEOUT_EN is defined.
module tb_nexthop_register_bank;

   localparam int NUM_IN  = 5;
   localparam int NUM_OUT = 4;
   localparam int ADDR_W  = 3;
   localparam int NULL_HP = 4;
   localparam int TO_CYC  = 16;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NUM_IN-1:0]        ib_empty_i;
   logic [NUM_IN-1:0]        nhr_write_i;
   logic [NUM_IN*ADDR_W-1:0] nhr_address_i;
   logic [NUM_IN-1:0]        nhr_tail_i;
   logic [NUM_IN*ADDR_W-1:0] nhr_address_o;
   logic [NUM_IN-1:0]        nhr_valid_o;
   logic [NUM_IN-1:0]        nhr_err_o;
   logic [NUM_OUT-1:0]       out_busy_o;
`ifdef NHR_TIMEOUT_EN
   logic [NUM_IN-1:0]        nhr_timeout_o;
`endif

   always #5 clk = ~clk;

   nexthop_register_bank #(
      .NUM_IN   (NUM_IN),
      .NUM_OUT  (NUM_OUT),
      .ADDR_W   (ADDR_W),
      .NULL_HOP (3'b100)
`ifdef NHR_TIMEOUT_EN
      ,.TO_CYC  (TO_CYC)
`endif
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ib_empty_i    (ib_empty_i),
      .nhr_write_i   (nhr_write_i),
      .nhr_address_i (nhr_address_i),
      .nhr_tail_i    (nhr_tail_i),
      .nhr_address_o (nhr_address_o),
      .nhr_valid_o   (nhr_valid_o),
      .nhr_err_o     (nhr_err_o),
      .out_busy_o    (out_busy_o)
`ifdef NHR_TIMEOUT_EN
      ,.nhr_timeout_o (nhr_timeout_o)
`endif
   );

   // Reference model: which port each channel owns, and how long it has starved.
   bit m_bound [NUM_IN];
   int m_hop   [NUM_IN];
   int m_stall [NUM_IN];
   bit m_err   [NUM_IN];
   bit m_to    [NUM_IN];

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      ib_empty_i    = '0;
      nhr_write_i   = '0;
      nhr_address_i = '0;
      nhr_tail_i    = '0;
   endtask

   task automatic drive(input int c, input bit w, input int a, input bit t, input bit e);
      nhr_write_i[c]                   = w;
      nhr_address_i[c*ADDR_W +: ADDR_W] = ADDR_W'(a);
      nhr_tail_i[c]                    = t;
      ib_empty_i[c]                    = e;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      for (int c = 0; c < NUM_IN; c++) begin
         bit w, t, e, good;
         int a;
         w = nhr_write_i[c];
         t = nhr_tail_i[c];
         e = ib_empty_i[c];
         a = int'(nhr_address_i[c*ADDR_W +: ADDR_W]);
         good = w && (a < NUM_OUT) && !e;
         m_err[c] = 0;
         m_to[c]  = 0;
         if (reset) begin
            m_bound[c] = 0;
            m_stall[c] = 0;
         end else if (!m_bound[c]) begin
            m_stall[c] = 0;
            if (good) begin
               m_bound[c] = 1;
               m_hop[c]   = a;
            end else if (w) begin
               m_err[c] = 1;
            end
         end else if (t) begin
            m_stall[c] = 0;
            if (good) m_hop[c] = a;
            else begin
               m_bound[c] = 0;
               m_err[c]   = w;
            end
         end else begin
            m_err[c] = w;
`ifdef NHR_TIMEOUT_EN
            if (e) begin
               m_stall[c]++;
               if (m_stall[c] == TO_CYC) begin
                  m_bound[c] = 0;
                  m_to[c]    = 1;
                  m_stall[c] = 0;
               end
            end else begin
               m_stall[c] = 0;
            end
`endif
         end
      end
   endtask

   task automatic compare_all();
      logic [NUM_IN-1:0]  ev, ee, et;
      logic [NUM_OUT-1:0] eb;
      eb = '0;
      for (int c = 0; c < NUM_IN; c++) begin
         ev[c] = m_bound[c];
         ee[c] = m_err[c];
         et[c] = m_to[c];
         if (m_bound[c]) eb[m_hop[c]] = 1'b1;
         check($sformatf("addr_ch%0d", c), 32'(nhr_address_o[c*ADDR_W +: ADDR_W]),
               m_bound[c] ? m_hop[c] : NULL_HP);
      end
      check("valid", 32'(nhr_valid_o), 32'(ev));
      check("err",   32'(nhr_err_o),   32'(ee));
      check("busy",  32'(out_busy_o),  32'(eb));
`ifdef NHR_TIMEOUT_EN
      check("timeout", 32'(nhr_timeout_o), 32'(et));
`else
      if (et != '0) check("timeout_model", 32'(et), 32'd0);
`endif
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      for (int c = 0; c < NUM_IN; c++) begin
         m_bound[c] = 0; m_hop[c] = 0; m_stall[c] = 0; m_err[c] = 0; m_to[c] = 0;
      end
      clear_inputs();

      // Reset, then idle.
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      check("reset_null_hops", 32'(nhr_address_o), {NUM_IN{3'b100}});

      // ch0 binds to port 2, holds for 3 cycles, releases on tail.
      drive(0, 1, 2, 0, 0);
      step();
      check("ch0_busy_p2", 32'(out_busy_o), 32'b0100);
      clear_inputs();
      repeat (3) step();
      drive(0, 0, 0, 1, 0);
      step();
      clear_inputs();
      step();

      // Illegal address on ch1, write with empty buffer on ch2.
      drive(1, 1, 5, 0, 0);
      drive(2, 1, 1, 0, 1);
      step();
      check("err_pulse_ch1_ch2", 32'(nhr_err_o), 32'b00110);
      clear_inputs();
      step();

      // ch3: bind, rejected write while bound, then tail+write rebind.
      drive(3, 1, 1, 0, 0);
      step();
      clear_inputs();
      drive(3, 1, 3, 0, 0);
      step();
      clear_inputs();
      step();
      drive(3, 1, 3, 1, 0);
      step();
      check("ch3_rebound", 32'(nhr_address_o[3*ADDR_W +: ADDR_W]), 32'd3);
      clear_inputs();
      step();

      // ch0 and ch4 share port 0; busy holds until both release.
      drive(0, 1, 0, 0, 0);
      drive(4, 1, 0, 0, 0);
      step();
      clear_inputs();
      step();
      drive(0, 0, 0, 1, 0);
      step();
      clear_inputs();
      step();
      step();
      drive(4, 0, 0, 1, 0);
      step();
      clear_inputs();
      drive(3, 0, 0, 1, 0);
      step();

      // Tail in IDLE is ignored; empty buffer while bound keeps the binding.
      clear_inputs();
      drive(1, 0, 0, 1, 0);
      step();
      drive(1, 0, 0, 0, 0);
      drive(2, 1, 2, 0, 0);
      step();
      clear_inputs();
      ib_empty_i[2] = 1'b1;
      repeat (5) step();
      drive(2, 0, 0, 1, 1);
      step();
      clear_inputs();
      step();

`ifdef NHR_TIMEOUT_EN
      // Sustained starvation forces a timeout release.
      drive(2, 1, 1, 0, 0);
      step();
      clear_inputs();
      ib_empty_i[2] = 1'b1;
      repeat (TO_CYC) step();
      check("timeout_release", 32'(nhr_timeout_o), 32'b00100);
      clear_inputs();
      step();
      // A bubble at cycle 10 restarts the count.
      drive(2, 1, 1, 0, 0);
      step();
      clear_inputs();
      ib_empty_i[2] = 1'b1;
      repeat (9) step();
      ib_empty_i[2] = 1'b0;
      step();
      ib_empty_i[2] = 1'b1;
      repeat (12) step();
      drive(2, 0, 0, 1, 0);
      step();
      // Tail on the expiring cycle wins over the timeout.
      clear_inputs();
      drive(2, 1, 0, 0, 0);
      step();
      clear_inputs();
      ib_empty_i[2] = 1'b1;
      repeat (TO_CYC - 1) step();
      drive(2, 0, 0, 1, 1);
      step();
      clear_inputs();
      step();
`endif

      // Reset mid-packet drops the binding on the same edge.
      drive(1, 1, 3, 0, 0);
      step();
      clear_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();

      // Random traffic, including illegal addresses and bubbles.
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < NUM_IN; c++)
            drive(c, ($urandom % 3) == 0, int'($urandom % 8), ($urandom % 4) == 0, ($urandom % 4) == 0);
         step();
      end
      clear_inputs();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
